pulse_qualifier_synch: RTL



---
 rtl/pulse_qualifier_synch.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pulse_qualifier_synch.sv
// Pulse qualifier: debounces a synchronous level, emits one-cycle rise/fall
// strobes and reports the qualified high duration in clock cycles.
module pulse_qualifier_synch #(
    parameter int unsigned par_T_qual_val  = 4,
    parameter int unsigned par_T_qual_bits = $clog2(par_T_qual_val),
    parameter int unsigned par_width_bits  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_x,
    output logic                      o_level,
    output logic                      o_pulse_rise,
    output logic                      o_pulse_fall,
    output logic [par_width_bits-1:0] o_width,
    output logic                      o_width_valid
);

    if (par_T_qual_val < 2) begin : g_bad_qual
        $error("pulse_qualifier_synch: par_T_qual_val must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_LOW,
        ST_QUAL_HI,
        ST_HIGH,
        ST_QUAL_LO
    } state_e;

    localparam int unsigned SumBits = par_width_bits + par_T_qual_bits + 1;

    // Timer value seen on the edge that delivers the Nth equal sample.
    localparam logic [par_T_qual_bits-1:0] TimerLast = par_T_qual_bits'(par_T_qual_val - 2);
    localparam logic [par_T_qual_bits-1:0] TimerMax  = par_T_qual_bits'(par_T_qual_val - 1);
    localparam logic [par_width_bits-1:0]  WidthMax  = '1;
    localparam logic [par_width_bits-1:0]  WidthOne  = par_width_bits'(1);

    state_e                      state_q, state_d;
    logic [par_T_qual_bits-1:0]  timer_q, timer_d;
    logic [par_width_bits-1:0]   width_cnt_q, width_cnt_d;
    logic [par_width_bits-1:0]   width_cnt_inc;
    logic [SumBits-1:0]          glitch_sum;
    logic [par_width_bits-1:0]   glitch_width;

    logic                        level_q, level_d;
    logic                        rise_q, rise_d;
    logic                        fall_q, fall_d;
    logic                        valid_q, valid_d;
    logic [par_width_bits-1:0]   width_q, width_d;

    assign width_cnt_inc = (width_cnt_q == WidthMax) ? width_cnt_q : width_cnt_q + WidthOne;

    // A rejected low glitch of (timer_q + 1) samples plus the current high sample
    // all belong to the high period.
    assign glitch_sum   = SumBits'(width_cnt_q) + SumBits'(timer_q) + SumBits'(2);
    assign glitch_width = (glitch_sum > SumBits'(WidthMax)) ? WidthMax
                                                            : glitch_sum[par_width_bits-1:0];

    always_comb begin
        state_d     = state_q;
        width_cnt_d = width_cnt_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        valid_d     = 1'b0;
        width_d     = width_q;

        unique case (state_q)
            ST_LOW: begin
                if (i_x) begin
                    state_d     = ST_QUAL_HI;
                    width_cnt_d = WidthOne;
                end
            end
            ST_QUAL_HI: begin
                if (!i_x) begin
                    state_d = ST_LOW;
                end else begin
                    width_cnt_d = width_cnt_inc;
                    if (timer_q == TimerLast) begin
                        state_d = ST_HIGH;
                        rise_d  = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (!i_x) begin
                    state_d = ST_QUAL_LO;
                end else begin
                    width_cnt_d = width_cnt_inc;
                end
            end
            ST_QUAL_LO: begin
                if (i_x) begin
                    state_d     = ST_HIGH;
                    width_cnt_d = glitch_width;
                end else if (timer_q == TimerLast) begin
                    state_d = ST_LOW;
                    fall_d  = 1'b1;
                    valid_d = 1'b1;
                    width_d = width_cnt_q;
                end
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == TimerMax) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + par_T_qual_bits'(1);
        end

        level_d = (state_d == ST_HIGH) || (state_d == ST_QUAL_LO);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_LOW;
            timer_q     <= '0;
            width_cnt_q <= '0;
            level_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            valid_q     <= 1'b0;
            width_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            width_cnt_q <= width_cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            valid_q     <= valid_d;
            width_q     <= width_d;
        end
    end

    assign o_level       = level_q;
    assign o_pulse_rise  = rise_q;
    assign o_pulse_fall  = fall_q;
    assign o_width       = width_q;
    assign o_width_valid = valid_q;

endmodule
